spi_frame_loader: RTL

Serial load controller that sits between the external master's chip-select/MOSI pins and the write ports of the instruction and data caches. It deframes fixed-length frames of one data byte plus one cache address, checks frame length, chip-select collisions and execution interlock, and issues exactly one cache write strobe per valid frame. It replaces ad-hoc shift-and-write gating with an explicit FSM that reports errors and keeps a count of committed frames.

---
 rtl/spi_frame_loader_if.sv | 31 +++
 rtl/spi_frame_loader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/spi_frame_loader_if.sv
// rtl/spi_frame_loader_if.sv - serial pin and cache write-port bundle for spi_frame_loader
interface spi_frame_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              csi_n;
    logic              csd_n;
    logic              mosi;
    logic              exec_in;
    logic              wr_en_out;
    logic              wr_sel_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [DATA_W-1:0] wr_data_out;
    logic              busy_out;
    logic              err_out;
    logic [7:0]        frame_cnt_out;

    // Loader side: consumes pins, drives the cache write port and status.
    modport slave (
        input  csi_n, csd_n, mosi, exec_in,
        output wr_en_out, wr_sel_out, wr_addr_out, wr_data_out,
        output busy_out, err_out, frame_cnt_out
    );

    // External master side: drives pins, observes the write port and status.
    modport master (
        output csi_n, csd_n, mosi, exec_in,
        input  wr_en_out, wr_sel_out, wr_addr_out, wr_data_out,
        input  busy_out, err_out, frame_cnt_out
    );
endinterface

// File: rtl/spi_frame_loader.sv
// rtl/spi_frame_loader.sv - serial frame deframer and cache write controller, optional parity via LOADER_PARITY_EN
module spi_frame_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    spi_frame_loader_if.slave bus
);
`ifdef LOADER_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_W = DATA_W + ADDR_W + PAR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DRAIN} state_t;

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               target;
    logic               wr_en;
    logic               busy;
    logic               err;
    logic [7:0]         frame_cnt;

    logic               tgt_cs_low;
    logic               oth_cs_low;
    logic               frame_ok;

    // The chip select that opened the frame versus the one that must stay quiet.
    assign tgt_cs_low = target ? !bus.csd_n : !bus.csi_n;
    assign oth_cs_low = target ? !bus.csi_n : !bus.csd_n;

`ifdef LOADER_PARITY_EN
    // Even parity: the XOR over the complete frame, parity bit included, must be zero.
    assign frame_ok = (bit_cnt == CNT_FULL) && !(^shreg);
`else
    assign frame_ok = (bit_cnt == CNT_FULL);
`endif

    // Deframing FSM; busy and the write strobe are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            target    <= 1'b0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.exec_in) begin
                        if (!bus.csi_n && !bus.csd_n) begin
                            err   <= 1'b1;
                            busy  <= 1'b1;
                            state <= DRAIN;
                        end else if (!bus.csi_n || !bus.csd_n) begin
                            target  <= !bus.csd_n;
                            shreg   <= {shreg[FRAME_W-2:0], bus.mosi};
                            bit_cnt <= CNT_W'(1);
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            state   <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // Abort and collision win over a simultaneous release.
                    if (bus.exec_in || oth_cs_low) begin
                        err   <= 1'b1;
                        state <= DRAIN;
                    end else if (tgt_cs_low) begin
                        shreg <= {shreg[FRAME_W-2:0], bus.mosi};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (frame_ok) begin
                        wr_en <= 1'b1;
                        state <= COMMIT;
                    end else begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                COMMIT: begin
                    frame_cnt <= frame_cnt + 8'd1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                DRAIN: begin
                    if (bus.csi_n && bus.csd_n) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_en_out     = wr_en;
    assign bus.busy_out      = busy;
    assign bus.err_out       = err;
    assign bus.frame_cnt_out = frame_cnt;
    assign bus.wr_sel_out    = target;
    assign bus.wr_data_out   = shreg[FRAME_W-1 -: DATA_W];
    assign bus.wr_addr_out   = shreg[PAR_W +: ADDR_W];
endmodule
